// File: rtl/sfq_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfq_arith_pkg
// Description : Shared opcode encodings and latency helper for SFQ arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package sfq_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Pipelined ripple adder latency: one clocked stage per result bit.
    function automatic int lat_adder(input int width);
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfq_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : sfq_fa_cell
// Description : One clocked full-adder stage (XOR/AND cell pair) with stall.
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic vld_in,
    output logic sum,
    output logic cout,
    output logic vld_out
);

    logic w_p;
    logic w_g;

    assign w_p = a ^ b;
    assign w_g = a & b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= 1'b0;
            cout    <= 1'b0;
            vld_out <= 1'b0;
        end else if (!stall) begin
            sum     <= w_p ^ cin;
            cout    <= w_g | (w_p & cin);
            vld_out <= vld_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfq_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : sfq_pipelined_adder
// Description : Bit-level pipelined ripple add/subtract; carry advances one
//               bit per clock, operands skewed in and sums deskewed out.
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_pipelined_adder
    import sfq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             in_valid,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LATENCY = lat_adder(WIDTH);

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;
    logic [WIDTH-1:0] w_stage_a;
    logic [WIDTH-1:0] w_stage_b;
    logic [WIDTH-1:0] w_stage_cin;
    logic [WIDTH-1:0] w_stage_vld;
    logic [WIDTH-1:0] w_cell_sum;
    logic [WIDTH-1:0] w_cell_cout;
    logic [WIDTH-1:0] w_cell_vld;
    logic [WIDTH-1:0] w_sum_out;
    logic             r_cin_msb;

    // Subtraction is a + ~b + 1; in_cin only matters for addition.
    assign w_b_eff = (in_sub == OP_ADD) ? in_b : ~in_b;
    assign w_cin0  = (in_sub == OP_SUB) ? 1'b1 : in_cin;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        localparam int DEPTH = LATENCY - 1 - k;

        if (k == 0) begin : g_entry
            assign w_stage_a[k]   = in_a[k];
            assign w_stage_b[k]   = w_b_eff[k];
            assign w_stage_cin[k] = w_cin0;
            assign w_stage_vld[k] = in_valid;
        end else begin : g_skew
            logic r_sa [k];
            logic r_sb [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        r_sa[i] <= 1'b0;
                        r_sb[i] <= 1'b0;
                    end
                end else if (!stall) begin
                    r_sa[0] <= in_a[k];
                    r_sb[0] <= w_b_eff[k];
                    for (int i = 1; i < k; i++) begin
                        r_sa[i] <= r_sa[i-1];
                        r_sb[i] <= r_sb[i-1];
                    end
                end
            end

            assign w_stage_a[k]   = r_sa[k-1];
            assign w_stage_b[k]   = r_sb[k-1];
            assign w_stage_cin[k] = w_cell_cout[k-1];
            assign w_stage_vld[k] = w_cell_vld[k-1];
        end

        sfq_fa_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall   (stall),
            .a       (w_stage_a[k]),
            .b       (w_stage_b[k]),
            .cin     (w_stage_cin[k]),
            .vld_in  (w_stage_vld[k]),
            .sum     (w_cell_sum[k]),
            .cout    (w_cell_cout[k]),
            .vld_out (w_cell_vld[k])
        );

        if (DEPTH == 0) begin : g_nodeskew
            assign w_sum_out[k] = w_cell_sum[k];
        end else begin : g_deskew
            logic r_ds [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_ds[i] <= 1'b0;
                    end
                end else if (!stall) begin
                    r_ds[0] <= w_cell_sum[k];
                    for (int i = 1; i < DEPTH; i++) begin
                        r_ds[i] <= r_ds[i-1];
                    end
                end
            end

            assign w_sum_out[k] = r_ds[DEPTH-1];
        end
    end

    // Carry into the MSB, captured on the same edge as the MSB cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cin_msb <= 1'b0;
        end else if (!stall) begin
            r_cin_msb <= w_stage_cin[WIDTH-1];
        end
    end

    assign out_valid = w_cell_vld[WIDTH-1];
    assign out_sum   = w_sum_out;
    assign out_cout  = w_cell_cout[WIDTH-1];
    assign out_ovf   = r_cin_msb ^ w_cell_cout[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_sfq_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfq_pipelined_adder
// Description : Directed vector table and scoreboarded sequences for the
//               pipelined adder at WIDTH 8, 1 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfq_pipelined_adder;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, in_sub, in_cin;
    logic        v8, v1, v32;
    logic [7:0]  a8, b8;
    logic [0:0]  a1, b1;
    logic [31:0] a32, b32;

    logic        ov8, oc8, oo8;
    logic [7:0]  os8;
    logic        ov1, oc1, oo1;
    logic [0:0]  os1;
    logic        ov32, oc32, oo32;
    logic [31:0] os32;

    sfq_pipelined_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(v8), .in_sub(in_sub),
        .in_a(a8), .in_b(b8), .in_cin(in_cin),
        .out_valid(ov8), .out_sum(os8), .out_cout(oc8), .out_ovf(oo8)
    );

    sfq_pipelined_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(v1), .in_sub(in_sub),
        .in_a(a1), .in_b(b1), .in_cin(in_cin),
        .out_valid(ov1), .out_sum(os1), .out_cout(oc1), .out_ovf(oo1)
    );

    sfq_pipelined_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(v32), .in_sub(in_sub),
        .in_a(a32), .in_b(b32), .in_cin(in_cin),
        .out_valid(ov32), .out_sum(os32), .out_cout(oc32), .out_ovf(oo32)
    );

    typedef struct {
        int          width;
        logic        sub;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         ucyc;
        int         acyc;
        int         abs_lat;
    } exp_t;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   ucyc     = 0;
    int   acyc     = 0;
    bit   mon_en   = 1'b0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs [17];

    always @(posedge clk) begin
        acyc <= acyc + 1;
        if (!stall) ucyc <= ucyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // {valid, ovf, cout, sum} of the instance with the given width
    function automatic logic [34:0] dut_out(input int w);
        case (w)
            8:       return {ov8, oo8, oc8, 24'd0, os8};
            1:       return {ov1, oo1, oc1, 31'd0, os1};
            default: return {ov32, oo32, oc32, os32};
        endcase
    endfunction

    // Arithmetic reference: returns {ovf, cout, sum[31:0]}
    function automatic logic [33:0] model(input int w, input logic sub, input logic cin,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [32:0] mask, bb, full, low;
        logic        c;
        mask = (33'd1 << w) - 33'd1;
        bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        c    = sub ? 1'b1 : cin;
        full = ({1'b0, a} & mask) + bb + {32'd0, c};
        low  = ({1'b0, a} & (mask >> 1)) + (bb & (mask >> 1)) + {32'd0, c};
        return {low[w-1] ^ full[w], full[w], full[31:0] & mask[31:0]};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int          lat, nvalid;
        logic [34:0] o, got;
        @(negedge clk);
        in_sub = v.sub;
        in_cin = v.cin;
        a8  = v.a[7:0];  b8  = v.b[7:0];
        a1  = v.a[0:0];  b1  = v.b[0:0];
        a32 = v.a;       b32 = v.b;
        case (v.width)
            8:       v8  = 1'b1;
            1:       v1  = 1'b1;
            default: v32 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        v8 = 1'b0; v1 = 1'b0; v32 = 1'b0;
        lat = -1; nvalid = 0; got = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            o = dut_out(v.width);
            if (o[34]) begin
                nvalid++;
                if (lat < 0) begin
                    lat = n;
                    got = o;
                end
            end
        end
        check($sformatf("vec%0d_w%0d_latency", idx, v.width), lat, v.width);
        check($sformatf("vec%0d_w%0d_pulses", idx, v.width), nvalid, 1);
        check($sformatf("vec%0d_w%0d_sum", idx, v.width), got[31:0], v.sum);
        check($sformatf("vec%0d_w%0d_cout", idx, v.width), got[32], v.cout);
        check($sformatf("vec%0d_w%0d_ovf", idx, v.width), got[33], v.ovf);
    endtask

    task automatic issue8(input logic sub, input logic cin, input logic [7:0] a,
                          input logic [7:0] b, input int abs_lat, input bit track);
        logic [33:0] m;
        exp_t        e;
        @(negedge clk);
        in_sub = sub; in_cin = cin; a8 = a; b8 = b; v8 = 1'b1;
        if (track) begin
            m = model(8, sub, cin, {24'd0, a}, {24'd0, b});
            e.sum = m[7:0]; e.cout = m[32]; e.ovf = m[33];
            e.ucyc = ucyc; e.acyc = acyc; e.abs_lat = abs_lat;
            sbq.push_back(e);
        end
    endtask

    task automatic idle8();
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic issue8_rand(input int abs_lat, input bit track);
        issue8(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), abs_lat, track);
    endtask

    always @(negedge clk) begin
        if (mon_en && ov8) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_valid: got out_valid=1 sum=%0h expected no result", os8);
            end else begin
                mon_e = sbq.pop_front();
                check("stream_sum", os8, mon_e.sum);
                check("stream_cout", oc8, mon_e.cout);
                check("stream_ovf", oo8, mon_e.ovf);
                check("stream_latency", ucyc - mon_e.ucyc, 8);
                check("stream_abs_latency", acyc - mon_e.acyc, mon_e.abs_lat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [34:0] snap;
        int          nv;

        vecs[0]  = '{8,  1'b0, 1'b0, 32'h0F,       32'h01,       32'h10,       1'b0, 1'b0};
        vecs[1]  = '{8,  1'b0, 1'b1, 32'hFF,       32'h00,       32'h00,       1'b1, 1'b0};
        vecs[2]  = '{8,  1'b0, 1'b0, 32'h7F,       32'h01,       32'h80,       1'b0, 1'b1};
        vecs[3]  = '{8,  1'b1, 1'b1, 32'h05,       32'h07,       32'hFE,       1'b0, 1'b0};
        vecs[4]  = '{8,  1'b1, 1'b0, 32'h80,       32'h01,       32'h7F,       1'b1, 1'b1};
        vecs[5]  = '{8,  1'b0, 1'b0, 32'hFF,       32'h01,       32'h00,       1'b1, 1'b0};
        vecs[6]  = '{8,  1'b1, 1'b0, 32'h10,       32'h10,       32'h00,       1'b1, 1'b0};
        vecs[7]  = '{1,  1'b0, 1'b1, 32'h1,        32'h0,        32'h0,        1'b1, 1'b0};
        vecs[8]  = '{1,  1'b0, 1'b0, 32'h1,        32'h1,        32'h0,        1'b1, 1'b1};
        vecs[9]  = '{1,  1'b0, 1'b1, 32'h0,        32'h0,        32'h1,        1'b0, 1'b1};
        vecs[10] = '{1,  1'b1, 1'b0, 32'h0,        32'h1,        32'h1,        1'b0, 1'b1};
        vecs[11] = '{1,  1'b1, 1'b0, 32'h1,        32'h1,        32'h0,        1'b1, 1'b0};
        vecs[12] = '{32, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0};
        vecs[13] = '{32, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{32, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[15] = '{32, 1'b1, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[16] = '{32, 1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};

        stall = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
        v8 = 1'b0; v1 = 1'b0; v32 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0; a32 = '0; b32 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_held_w8", dut_out(8), 0);
        check("reset_held_w1", dut_out(1), 0);
        check("reset_held_w32", dut_out(32), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_release_w8", dut_out(8), 0);
        check("after_release_w1", dut_out(1), 0);
        check("after_release_w32", dut_out(32), 0);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Back-to-back stream, then op/op/bubble pattern
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) issue8_rand(8, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) idle8();
            else issue8_rand(8, 1'b1);
        end
        idle8();
        repeat (12) @(negedge clk);
        check("stream_drain", sbq.size(), 0);

        // Four-cycle stall while three ops are in flight
        for (int i = 0; i < 3; i++) issue8_rand(12, 1'b1);
        idle8();
        @(negedge clk);
        snap  = dut_out(8);
        stall = 1'b1;
        v8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", n), dut_out(8), snap);
        end
        stall = 1'b0;
        v8    = 1'b0;
        repeat (14) @(negedge clk);
        check("stall_drain", sbq.size(), 0);

        // Asynchronous reset pulse with five ops in flight
        for (int i = 0; i < 5; i++) issue8_rand(8, 1'b0);
        idle8();
        idle8();
        #1 rst_n = 1'b0;
        #1 check("reset_async_w8", dut_out(8), 0);
        #1 rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) nv++;
        end
        check("reset_no_valid", nv, 0);
        issue8_rand(8, 1'b1);
        idle8();
        repeat (10) @(negedge clk);
        check("reset_recover_drain", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
